// File: rtl/keypad_pkg.sv
// Shared keypad constants: active-low row/column patterns, FSM states and the
// code-to-{row, column} key map used by the emulator.
package keypad_pkg;

  localparam int CNT_W = 20;

  localparam logic [3:0] NO_KEY   = 4'b1111;
  localparam logic [3:0] ROW_PAT0 = 4'b0111;
  localparam logic [3:0] ROW_PAT1 = 4'b1011;
  localparam logic [3:0] ROW_PAT2 = 4'b1101;
  localparam logic [3:0] ROW_PAT3 = 4'b1110;
  localparam logic [3:0] COL_PAT0 = 4'b0111;
  localparam logic [3:0] COL_PAT1 = 4'b1011;
  localparam logic [3:0] COL_PAT2 = 4'b1101;
  localparam logic [3:0] COL_PAT3 = 4'b1110;

  typedef enum logic [1:0] {
    IDLE,
    BOUNCE,
    HOLD,
    GAP
  } state_t;

  // Each entry is {row, col}; listed from key F down to key 0.
  localparam logic [15:0][7:0] KEY_MAP = {
    {ROW_PAT3, COL_PAT1},
    {ROW_PAT3, COL_PAT2},
    {ROW_PAT3, COL_PAT3},
    {ROW_PAT2, COL_PAT3},
    {ROW_PAT1, COL_PAT3},
    {ROW_PAT0, COL_PAT3},
    {ROW_PAT2, COL_PAT2},
    {ROW_PAT2, COL_PAT1},
    {ROW_PAT2, COL_PAT0},
    {ROW_PAT1, COL_PAT2},
    {ROW_PAT1, COL_PAT1},
    {ROW_PAT1, COL_PAT0},
    {ROW_PAT0, COL_PAT2},
    {ROW_PAT0, COL_PAT1},
    {ROW_PAT0, COL_PAT0},
    {ROW_PAT3, COL_PAT0}
  };

endpackage

// File: rtl/keypad_map.sv
// Combinational lookup from a hex key code to its active-low row and column.
module keypad_map
  import keypad_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [3:0] o_row,
  output logic [3:0] o_col
);

  assign {o_row, o_col} = KEY_MAP[i_code];

endmodule

// File: rtl/keypad_emulator.sv
// Emulates a 4x4 matrix keypad: accepts key-press requests and answers the
// scanner's column drive with the matching row while the contact is closed.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 800000,
  parameter int unsigned GAP_CYCLES    = 400000,
  parameter int unsigned BOUNCE_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] Col,
  output logic [3:0] Row,
  output logic       pressed
);

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_code;
  logic             r_pressed;
  logic             r_ready;
  logic [3:0]       r_row;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [3:0]       w_row_pat;
  logic [3:0]       w_col_pat;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  keypad_map u_map (
    .i_code (r_code),
    .o_row  (w_row_pat),
    .o_col  (w_col_pat)
  );

  // The counter restarts on every state entry; pressed and key_ready are
  // registered alongside the state so they change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_code    <= '0;
      r_pressed <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (key_valid) begin
            r_code  <= key_code;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            if (BOUNCE_CYCLES != 0) begin
              r_state   <= BOUNCE;
              r_pressed <= 1'b0;
            end else begin
              r_state   <= HOLD;
              r_pressed <= 1'b1;
            end
          end
        end
        BOUNCE: begin
          if (r_cnt == BOUNCE_LAST) begin
            r_state   <= HOLD;
            r_cnt     <= '0;
            r_pressed <= 1'b1;
          end else begin
            r_cnt     <= w_cnt_inc;
            r_pressed <= w_cnt_inc[4];
          end
        end
        HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_cnt     <= '0;
            r_pressed <= 1'b0;
            if (GAP_CYCLES != 0) begin
              r_state <= GAP;
            end else begin
              r_state <= IDLE;
              r_ready <= 1'b1;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_cnt     <= '0;
          r_pressed <= 1'b0;
          r_ready   <= 1'b1;
        end
      endcase
    end
  end

  // A column drive with zero or several low bits can never equal a single-low
  // key column, so malformed scans fall through to no-key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= NO_KEY;
    end else if (r_pressed && (Col == w_col_pat)) begin
      r_row <= w_row_pat;
    end else begin
      r_row <= NO_KEY;
    end
  end

  assign key_ready = r_ready;
  assign Row       = r_row;
  assign pressed   = r_pressed;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: three parameter sets share one stimulus stream and
// are compared every cycle against a press-timeline reference model.
module tb_keypad_emulator;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic [3:0] Col;

  logic [3:0] row_o   [3];
  logic       prs_o   [3];
  logic       rdy_o   [3];
  logic [3:0] exp_row [3];
  logic       exp_prs [3];
  logic       exp_rdy [3];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key map written straight from the keypad layout: column by group, row by
  // position within the group.
  function automatic logic [7:0] ref_key(input logic [3:0] c);
    logic [3:0] col;
    logic [3:0] row;
    col = 4'b1110;
    row = 4'b1110;
    case (c)
      4'h1, 4'h4, 4'h7, 4'h0: col = 4'b0111;
      4'h2, 4'h5, 4'h8, 4'hF: col = 4'b1011;
      4'h3, 4'h6, 4'h9, 4'hE: col = 4'b1101;
      default:                col = 4'b1110;
    endcase
    case (c)
      4'h1, 4'h2, 4'h3, 4'hA: row = 4'b0111;
      4'h4, 4'h5, 4'h6, 4'hB: row = 4'b1011;
      4'h7, 4'h8, 4'h9, 4'hC: row = 4'b1101;
      default:                row = 4'b1110;
    endcase
    return {row, col};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gen_cfg
    localparam int H = (g == 0) ? 64 : (g == 1) ? 20 : 16;
    localparam int G = (g == 0) ? 32 : (g == 1) ? 8 : 0;
    localparam int B = (g == 1) ? 64 : 0;

    // Model state: whether a press was ever accepted, cycles since the last
    // accept, the accepted code and the expected registered row.
    logic        m_busy;
    int unsigned m_age;
    logic [3:0]  m_code;
    logic [3:0]  m_row;
    logic [7:0]  m_map;
    logic        m_press;
    logic        m_ready;

    assign m_map   = ref_key(m_code);
    assign m_ready = !m_busy || (m_age >= B + H + G);
    assign m_press = m_busy && ((m_age < B) ? (((m_age / 16) % 2) == 1) : (m_age < B + H));

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_busy <= 1'b0;
        m_age  <= 0;
        m_code <= 4'h0;
        m_row  <= 4'hF;
      end else begin
        m_row <= (m_press && (Col == m_map[3:0])) ? m_map[7:4] : 4'hF;
        if (m_ready && key_valid) begin
          m_busy <= 1'b1;
          m_age  <= 0;
          m_code <= key_code;
        end else if (m_busy) begin
          m_age <= m_age + 1;
        end
      end
    end

    assign exp_row[g] = m_row;
    assign exp_prs[g] = m_press;
    assign exp_rdy[g] = m_ready;

    keypad_emulator #(
      .HOLD_CYCLES   (H),
      .GAP_CYCLES    (G),
      .BOUNCE_CYCLES (B)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_ready (rdy_o[g]),
      .Col       (Col),
      .Row       (row_o[g]),
      .pressed   (prs_o[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: compare every instance at the falling edge, then drive inputs.
  task automatic cyc(input logic v, input logic [3:0] code, input logic [3:0] col);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("row%0d", i), 32'(row_o[i]), 32'(exp_row[i]));
      check_eq($sformatf("pressed%0d", i), 32'(prs_o[i]), 32'(exp_prs[i]));
      check_eq($sformatf("ready%0d", i), 32'(rdy_o[i]), 32'(exp_rdy[i]));
    end
    key_valid = v;
    key_code  = code;
    Col       = col;
  endtask

  function automatic logic [3:0] one_col(input int k);
    logic [3:0] c;
    c = 4'b1111;
    c[k] = 1'b0;
    return c;
  endfunction

  initial begin
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    Col       = 4'hF;
    repeat (3) cyc(1'b0, 4'h0, 4'hF);
    rst_n = 1'b1;

    // Key 5: matching column, wrong column, then matching again
    cyc(1'b1, 4'h5, 4'b1011);
    repeat (20) cyc(1'b0, 4'h5, 4'b1011);
    repeat (10) cyc(1'b0, 4'h5, 4'b0111);
    repeat (90) cyc(1'b0, 4'h5, 4'b1011);

    // Key A held on its column through bounce and hold
    cyc(1'b1, 4'hA, 4'b1110);
    repeat (110) cyc(1'b0, 4'hA, 4'b1110);

    // Key 9 pressed, then a request for 3 arrives while busy
    cyc(1'b1, 4'h9, 4'b1101);
    repeat (5) cyc(1'b0, 4'h9, 4'b1101);
    repeat (3) cyc(1'b1, 4'h3, 4'b1101);
    repeat (4) cyc(1'b0, 4'h3, 4'b1101);

    // Asynchronous reset in the middle of the press
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("arst_row%0d", i), 32'(row_o[i]), 32'h0000000F);
      check_eq($sformatf("arst_pressed%0d", i), 32'(prs_o[i]), 32'h0);
      check_eq($sformatf("arst_ready%0d", i), 32'(rdy_o[i]), 32'h1);
    end
    repeat (2) cyc(1'b0, 4'h0, 4'b1101);
    cyc(1'b1, 4'h7, 4'b0111);
    #3 rst_n = 1'b1;
    repeat (100) cyc(1'b0, 4'h7, 4'b0111);

    // key_valid held high: back-to-back accepts, with malformed column drives
    for (int i = 0; i < 150; i++) begin
      cyc(1'b1, 4'($urandom_range(0, 15)),
          ($urandom_range(0, 2) == 0) ? 4'b1001 : one_col(int'($urandom_range(0, 3))));
    end

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)),
          ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                      : one_col(int'($urandom_range(0, 3))));
    end

    cyc(1'b0, 4'h0, 4'hF);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
